// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front panel: FSM encoding, MM:SS limits
// and saturating time arithmetic helpers.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SEC_MAX = 59;
  localparam int TIME_W  = 6;

  // Add one minute, clamping at max_m; 7-bit intermediate catches overflow.
  function automatic logic [TIME_W-1:0] add_min(input logic [TIME_W-1:0] m,
                                                 input int max_m);
    logic [TIME_W:0] m7;
    m7 = {1'b0, m} + 7'd1;
    if (m7 > 7'(max_m)) m7 = 7'(max_m);
    return m7[TIME_W-1:0];
  endfunction

  // Add step seconds with carry into minutes; overflow past max_m pins the
  // display at max_m:59. Result is {min, sec}.
  function automatic logic [2*TIME_W-1:0] add_sec(input logic [TIME_W-1:0] m,
                                                  input logic [TIME_W-1:0] s,
                                                  input int step,
                                                  input int max_m);
    logic [TIME_W:0] m7;
    logic [TIME_W:0] s7;
    m7 = {1'b0, m};
    s7 = {1'b0, s} + 7'(step);
    if (s7 > 7'(SEC_MAX)) begin
      s7 = s7 - 7'd60;
      m7 = m7 + 7'd1;
    end
    if (m7 > 7'(max_m)) begin
      m7 = 7'(max_m);
      s7 = 7'(SEC_MAX);
    end
    return {m7[TIME_W-1:0], s7[TIME_W-1:0]};
  endfunction

endpackage

// File: rtl/microwave_timer_ctrl_tick_gen.sv
// 1 Hz tick prescaler. Counts only while enabled; clr restarts the second so
// the first tick lands exactly TICK_DIV cycles after it.
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_reg;
  logic          wrap;

  assign wrap = (cnt_reg == CW'(TICK_DIV - 1));
  assign tick = en && wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cook-timer sequencer: button/door handling, MM:SS hold and 1 Hz countdown,
// feeding fnd_controller (min/sec/done) and the heater enable (run).
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int SEC_STEP  = 10,
  parameter int QUICK_SEC = 30,
  parameter int DONE_SEC  = 3,
  parameter int MAX_MIN   = 59
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic              btn_stop,
  input  logic              btn_min,
  input  logic              btn_sec,
  input  logic              door_open,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] sec,
  output logic              run,
  output logic              done,
  output logic [1:0]        state
);

  localparam int DCW = (DONE_SEC > 1) ? $clog2(DONE_SEC + 1) : 1;
  localparam logic [TIME_W-1:0] QUICK_M = TIME_W'(QUICK_SEC / 60);
  localparam logic [TIME_W-1:0] QUICK_S = TIME_W'(QUICK_SEC % 60);

  state_t            state_reg, state_next;
  logic [TIME_W-1:0] min_reg, min_next;
  logic [TIME_W-1:0] sec_reg, sec_next;
  logic [DCW-1:0]    done_cnt_reg, done_cnt_next;
  logic              run_reg, done_reg;
  logic [TIME_W-1:0] run_min, run_sec;
  logic              tick, tick_clr, tick_en;
  logic              any_event;

  assign tick_en   = (state_reg == RUN) || (state_reg == DONE);
  assign tick_clr  = (state_next != state_reg) &&
                     ((state_next == RUN) || (state_next == DONE));
  assign any_event = door_open | btn_stop | btn_start | btn_min | btn_sec;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_next    = state_reg;
    min_next      = min_reg;
    sec_next      = sec_reg;
    done_cnt_next = done_cnt_reg;
    run_min       = min_reg;
    run_sec       = sec_reg;
    case (state_reg)
      // In IDLE/PAUSE an open door only blocks start; time can still be edited.
      IDLE, PAUSE: begin
        if (btn_stop) begin
          state_next = IDLE;
          min_next   = '0;
          sec_next   = '0;
        end else if (btn_start) begin
          if (!door_open) begin
            state_next = RUN;
            if (min_reg == '0 && sec_reg == '0) begin
              min_next = QUICK_M;
              sec_next = QUICK_S;
            end
          end
        end else if (btn_min) begin
          min_next = add_min(min_reg, MAX_MIN);
        end else if (btn_sec) begin
          {min_next, sec_next} = add_sec(min_reg, sec_reg, SEC_STEP, MAX_MIN);
        end
      end
      RUN: begin
        if (door_open || btn_stop) begin
          state_next = PAUSE;
        end else begin
          if (btn_min && !btn_start) run_min = add_min(min_reg, MAX_MIN);
          if (tick) begin
            if (run_sec != '0) begin
              run_sec = run_sec - 6'd1;
            end else if (run_min != '0) begin
              run_sec = TIME_W'(SEC_MAX);
              run_min = run_min - 6'd1;
            end
          end
          min_next = run_min;
          sec_next = run_sec;
          if (run_min == '0 && run_sec == '0) begin
            state_next    = DONE;
            done_cnt_next = '0;
          end
        end
      end
      DONE: begin
        min_next = '0;
        sec_next = '0;
        if (any_event) begin
          state_next = IDLE;
        end else if (tick) begin
          if (done_cnt_reg == DCW'(DONE_SEC - 1)) state_next = IDLE;
          else done_cnt_next = done_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // run/done are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      min_reg      <= '0;
      sec_reg      <= '0;
      done_cnt_reg <= '0;
      run_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      min_reg      <= min_next;
      sec_reg      <= sec_next;
      done_cnt_reg <= done_cnt_next;
      run_reg      <= (state_next == RUN);
      done_reg     <= (state_next == DONE);
    end
  end

  assign min   = min_reg;
  assign sec   = sec_reg;
  assign run   = run_reg;
  assign done  = done_reg;
  assign state = state_reg;

endmodule
